// File: rtl/fx_mac_sequencer.sv
// fx_mac_sequencer: operand FIFO and sequencer feeding the FX 16x16 signed MAC.
// Buffers signed operand pairs, streams one term per cycle into the MAC, reads the
// accumulator back and holds the dot-product result behind a valid/ready handshake.
// Optional feature macro: FX_MAC_SEQ_FRAC_EN. When defined, the captured result is
// rescaled by FRAC_BITS with round-half-up. When undefined, the raw MAC value is kept.
module fx_mac_sequencer #(
    parameter int DEPTH     = 4,
    parameter int TERM_W    = 8,
    parameter int FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              reset_accum,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [15:0]       push_a,
    input  logic [15:0]       push_b,
    input  logic              push_sub,
    input  logic              push_last,
    output logic [15:0]       mac_a,
    output logic [15:0]       mac_b,
    output logic              mac_mult_enabled,
    output logic              mac_accumulate,
    output logic              mac_add_or_sub,
    output logic              mac_clear,
    input  logic [31:0]       mac_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic [TERM_W-1:0] res_terms,
    output logic              res_sat,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [TERM_W-1:0] TERM_MAX = '1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fx_mac_sequencer: DEPTH must be a power of two >= 2");
    end
    if (FRAC_BITS < 1 || FRAC_BITS > 31) begin : g_bad_frac
        $error("fx_mac_sequencer: FRAC_BITS must be in 1..31");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        CLEAR   = 3'd4
    } state_t;

    state_t state, state_next;

    // Operand FIFO storage; data is never reset, only the pointers are.
    logic [15:0]      fifo_a [DEPTH];
    logic [15:0]      fifo_b [DEPTH];
    logic [DEPTH-1:0] fifo_sub;
    logic [DEPTH-1:0] fifo_last;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, do_push, do_pop;
    logic [AW-1:0]    rd_idx, wr_idx;

    logic [TERM_W-1:0] count;
    logic              sat;
    logic              clear_q;
    logic [31:0]       capture_value;

    assign rd_idx     = rd_ptr[AW-1:0];
    assign wr_idx     = wr_ptr[AW-1:0];
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign do_pop     = (state == ACCUM) && !empty;

`ifdef FX_MAC_SEQ_FRAC_EN
    localparam logic signed [32:0] HALF_LSB = 33'sd1 <<< (FRAC_BITS - 1);

    // Fixed-point rescale: add half an output LSB, then arithmetic shift (round half up).
    function automatic logic [31:0] round_frac(input logic [31:0] p);
        logic signed [32:0] s;
        s = $signed({p[31], p}) + HALF_LSB;
        s = s >>> FRAC_BITS;
        return s[31:0];
    endfunction

    assign capture_value = round_frac(mac_result);
`else
    assign capture_value = mac_result;
`endif

    // Write accepted operand pairs into the FIFO slot at the write pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_a[wr_idx]    <= push_a;
            fifo_b[wr_idx]    <= push_b;
            fifo_sub[wr_idx]  <= push_sub;
            fifo_last[wr_idx] <= push_last;
        end
    end

    // FIFO pointers: advance on accepted push and on ACCUM pop.
    always_ff @(posedge clk or posedge reset_accum) begin
        if (reset_accum) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // State register plus the dedicated flop that drives the MAC clear pulse.
    always_ff @(posedge clk or posedge reset_accum) begin
        if (reset_accum) begin
            state   <= IDLE;
            clear_q <= 1'b0;
        end else begin
            state   <= state_next;
            clear_q <= (state_next == CLEAR);
        end
    end

    // Next-state and MAC control decode; MAC operands come straight from the FIFO head.
    always_comb begin
        state_next       = state;
        mac_a            = '0;
        mac_b            = '0;
        mac_mult_enabled = 1'b0;
        mac_accumulate   = 1'b0;
        mac_add_or_sub   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_next = ACCUM;
            end
            ACCUM: begin
                mac_mult_enabled = 1'b1;
                if (!empty) begin
                    mac_a          = fifo_a[rd_idx];
                    mac_b          = fifo_b[rd_idx];
                    mac_add_or_sub = fifo_sub[rd_idx];
                    mac_accumulate = 1'b1;
                    if (fifo_last[rd_idx]) state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                // Zero product with accumulate low makes P equal the accumulator.
                mac_mult_enabled = 1'b1;
                state_next       = HOLD;
            end
            HOLD: begin
                if (res_ready) state_next = CLEAR;
            end
            CLEAR: begin
                state_next = empty ? IDLE : ACCUM;
            end
            default: state_next = IDLE;
        endcase
    end

    // Term counter saturates at all-ones; the saturation flag sticks until CLEAR.
    always_ff @(posedge clk or posedge reset_accum) begin
        if (reset_accum) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (state == CLEAR) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (do_pop && count != TERM_MAX) begin
            count <= count + 1'b1;
            if (count == TERM_MAX - 1'b1) sat <= 1'b1;
        end
    end

    // Capture the accumulator readback and term count; held stable through HOLD.
    always_ff @(posedge clk or posedge reset_accum) begin
        if (reset_accum) begin
            res_data  <= '0;
            res_terms <= '0;
        end else if (state == CAPTURE) begin
            res_data  <= capture_value;
            res_terms <= count;
        end
    end

    assign mac_clear = clear_q;
    assign res_valid = (state == HOLD);
    assign res_sat   = sat;
    assign busy      = (state != IDLE) || !empty;

endmodule
